// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock.
// Valid/ready in, valid/ready out, runtime signed/unsigned mode.
module booth_mult_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH/2+2)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int EW = WIDTH + 2;
  localparam int AW = 2 * EW;
  localparam int N  = WIDTH/2 + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               r_state;
  logic [EW-1:0]        r_a;
  logic                 r_am1;
  logic [AW-1:0]        r_b;
  logic [AW-1:0]        r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_prod;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;

  logic [EW-1:0]        w_a_ext;
  logic [AW-1:0]        w_b_ext;
  logic [2:0]           w_dig;
  logic [AW-1:0]        w_sel;
  logic                 w_neg;
  logic [AW-1:0]        w_addend;
  logic [AW-1:0]        w_acc_nx;
  logic                 w_last;

  assign w_a_ext = is_signed ? {{2{a[WIDTH-1]}}, a}
                             : {2'b00, a};
  assign w_b_ext = is_signed ? {{(AW-WIDTH){b[WIDTH-1]}}, b}
                             : {{(AW-WIDTH){1'b0}}, b};

  // r_a shifts right and r_b left, so the digit is always at the bottom
  assign w_dig = {r_a[1:0], r_am1};

  always_comb begin
    w_sel = '0;
    w_neg = 1'b0;
    unique case (w_dig)
      3'b001, 3'b010: w_sel = r_b;
      3'b011:         w_sel = r_b << 1;
      3'b100: begin
        w_sel = r_b << 1;
        w_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        w_sel = r_b;
        w_neg = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_addend = w_neg ? ~w_sel : w_sel;
  assign w_acc_nx = r_acc + w_addend + AW'(w_neg);
  assign w_last   = (r_cnt == CNT_W'(N-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_am1       <= 1'b0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_prod      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= w_a_ext;
            r_am1      <= 1'b0;
            r_b        <= w_b_ext;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_acc_nx;
          r_a   <= r_a >> 2;
          r_am1 <= r_a[1];
          r_b   <= r_b << 2;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_prod      <= w_acc_nx[2*WIDTH-1:0];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_prod;
  assign busy      = r_busy;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at WIDTH=8 and WIDTH=16.
// Expected products come from a longint reference model.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        iv8 = 0, rdy8, s8 = 0, ov8, ordy8 = 1, busy8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8;

  logic        iv16 = 0, rdy16, s16 = 0, ov16, ordy16 = 1, busy16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] p16;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] q8[$];
  logic [31:0] q16[$];
  int          ot8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  booth_mult_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(rdy8),
    .a(a8), .b(b8), .is_signed(s8),
    .out_valid(ov8), .out_ready(ordy8),
    .product(p8), .busy(busy8)
  );

  booth_mult_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(rdy16),
    .a(a16), .b(b16), .is_signed(s16),
    .out_valid(ov16), .out_ready(ordy16),
    .product(p16), .busy(busy16)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_mul(input int w,
                                          input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic s);
    longint x, y, p;
    if (w == 8) begin
      x = s ? longint'($signed(a[7:0])) : longint'({56'd0, a[7:0]});
      y = s ? longint'($signed(b[7:0])) : longint'({56'd0, b[7:0]});
    end else begin
      x = s ? longint'($signed(a)) : longint'({48'd0, a});
      y = s ? longint'($signed(b)) : longint'({48'd0, b});
    end
    p = x * y;
    return (w == 8) ? {16'd0, p[15:0]} : p[31:0];
  endfunction

  always @(negedge clk) begin
    if (ov8 && ordy8) begin
      if (q8.size() == 0) chk("spur8", 32'd1, 32'd0);
      else chk("prod8", {16'd0, p8}, q8.pop_front());
      ot8.push_back(cyc);
    end
    if (ov16 && ordy16) begin
      if (q16.size() == 0) chk("spur16", 32'd1, 32'd0);
      else chk("prod16", p16, q16.pop_front());
    end
  end

  function automatic logic rdy_of(input int w);
    return (w == 8) ? rdy8 : rdy16;
  endfunction

  function automatic logic ov_of(input int w);
    return (w == 8) ? ov8 : ov16;
  endfunction

  task automatic send(input int w,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input logic s,
                      input bit wait_out,
                      output int lat);
    int t;
    @(negedge clk);
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; s8 = s; iv8 = 1;
    end else begin
      a16 = a; b16 = b; s16 = s; iv16 = 1;
    end
    t = 0;
    while (!rdy_of(w) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("cap_timeout", 32'd0, 32'd1);
    if (w == 8) q8.push_back(ref_mul(w, a, b, s));
    else q16.push_back(ref_mul(w, a, b, s));
    @(posedge clk);
    #1;
    if (w == 8) iv8 = 0;
    else iv16 = 0;
    lat = 0;
    if (wait_out) begin
      while (!ov_of(w) && lat < 100) begin
        @(posedge clk);
        lat++;
        #1;
      end
    end
  endtask

  initial begin
    int lat;
    int t;
    #12;
    chk("rst_rdy", {31'd0, rdy8}, 32'd1);
    chk("rst_ov", {31'd0, ov8}, 32'd0);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_prod", {16'd0, p8}, 32'd0);
    @(negedge clk);
    rst_n = 1;

    send(8, 16'h00FF, 16'h00FF, 1'b0, 1, lat);
    chk("lat8", lat, 5);
    send(8, 16'h0080, 16'h0080, 1'b1, 1, lat);
    send(8, 16'h00FF, 16'h0001, 1'b1, 1, lat);
    send(8, 16'h007F, 16'h0080, 1'b1, 1, lat);
    send(8, 16'h0080, 16'h0080, 1'b0, 1, lat);

    // backpressure window
    @(posedge clk);
    #1 ordy8 = 0;
    send(8, 16'h00FB, 16'h000B, 1'b1, 1, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_prod", {16'd0, p8}, 32'h0000FFC9);
      chk("bp_ov", {31'd0, ov8}, 32'd1);
      chk("bp_rdy", {31'd0, rdy8}, 32'd0);
      iv8 = i[0];
      a8 = 8'(i + 1);
      b8 = 8'd3;
    end
    @(posedge clk);
    #1;
    iv8 = 0;
    ordy8 = 1;
    @(posedge clk);
    #1;
    chk("bp_rel_ov", {31'd0, ov8}, 32'd0);
    chk("bp_rel_rdy", {31'd0, rdy8}, 32'd1);

    // back-to-back with in_valid held high
    ot8.delete();
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd5; s8 = 1; iv8 = 1;
    t = 0;
    while (!rdy8 && t < 100) begin @(negedge clk); t++; end
    q8.push_back(32'h0000000F);
    @(posedge clk);
    @(negedge clk);
    a8 = 8'hF9; b8 = 8'd9; s8 = 1;
    t = 0;
    while (!rdy8 && t < 100) begin @(negedge clk); t++; end
    q8.push_back(32'h0000FFC1);
    @(posedge clk);
    #1 iv8 = 0;
    t = 0;
    while (ot8.size() < 2 && t < 100) begin @(negedge clk); t++; end
    if (ot8.size() < 2) chk("b2b_timeout", ot8.size(), 2);
    else chk("b2b_gap", ot8[1] - ot8[0], 7);

    // async reset during RUN cycle 2
    send(8, 16'h0064, 16'h0003, 1'b0, 0, lat);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("ar_rdy", {31'd0, rdy8}, 32'd1);
    chk("ar_ov", {31'd0, ov8}, 32'd0);
    chk("ar_busy", {31'd0, busy8}, 32'd0);
    chk("ar_prod", {16'd0, p8}, 32'd0);
    q8.delete();
    @(negedge clk);
    rst_n = 1;
    send(8, 16'h0006, 16'h0007, 1'b0, 1, lat);
    chk("lat8_post", lat, 5);

    for (int i = 0; i < 2000; i++) begin
      send(16, 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)), 1, lat);
      chk("lat16", lat, 9);
    end

    repeat (3) @(negedge clk);
    chk("q8_drain", q8.size(), 0);
    chk("q16_drain", q16.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Iterative radix-4 Booth multiplier with parametrised operand width and a runtime signed/unsigned mode. It retires one Booth digit per clock, recoding the digit and accumulating its shifted partial product (0, ±B, ±2B) into a running accumulator. Operands enter through a valid/ready handshake and the product leaves through a second valid/ready handshake. It is the area-lean alternative to a fully parallel partial-product array plus compressor tree in the datapath.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4
CNT_W, $clog2(WIDTH/2+2), iteration counter width (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands present
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplier (Booth-recoded operand)
b  input  WIDTH  multiplicand
is_signed  input  1  1 = both operands two's complement; 0 = both unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  a*b; two's complement when signed, unsigned otherwise
busy  output  1  high in RUN or DONE

Behaviour:
- One clock domain. Reset is asynchronous and active-low: assertion forces IDLE immediately, independent of clk.
- Reset values: in_ready=1, out_valid=0, busy=0, product=0, accumulator=0, counter=0.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid=1 at a rising edge, capture the operands and go to RUN.
  - Each operand is extended to WIDTH+2 bits: sign-extended when is_signed=1, zero-extended when 0.
  - is_signed is sampled only at capture.
  - Clear the accumulator and load counter=0.
- RUN: in_ready=0. Each cycle k (0..N-1), where N = WIDTH/2+1, does the following:
  - Recode digit triple {a_ext[2k+1], a_ext[2k], a_ext[2k-1]}, with a_ext[-1]=0.
  - 000/111 -> 0; 001/010 -> +B; 011 -> +2B; 100 -> -2B; 101/110 -> -B.
  - Add the selected value, sign-extended to 2*(WIDTH+2) bits and shifted left by 2k, into the accumulator. Arithmetic is modulo 2^(2*(WIDTH+2)).
  - Negation is two's complement: invert plus carry-in.
  - After cycle N-1, go to DONE.
- The recoding table is the same for both modes. Zero-extension makes unsigned operands non-negative, so the extra digit handles the unsigned MSB.
- DONE: out_valid=1. product = accumulator[2*WIDTH-1:0], registered and held stable while out_valid=1 and out_ready=0.
  - If out_ready=1 at the edge, go to IDLE and drop out_valid.
  - in_ready stays 0 in DONE; there is no overlap of a new capture with output hold.
- Latency: capture at edge T gives out_valid=1 after edge T+N (N=5 for WIDTH=8). Throughput is one product per N+2 cycles with out_ready held high.
- product holds its last value in IDLE and RUN. It is meaningful only while out_valid=1.
- Overflow is impossible: 2*WIDTH bits always hold the exact product in the selected mode.
- in_valid asserted while not in IDLE is ignored. Operand changes during RUN have no effect.
- Reset asserted mid-RUN or in DONE aborts the operation: no out_valid pulse, and the block returns to IDLE with the reset values above.
- busy = (state != IDLE).

Test Plan:
- WIDTH=8, unsigned, a=255, b=255, out_ready=1 -> out_valid rises 5 cycles after the handshake; product=0xFE01 (65025).
- WIDTH=8, signed: check the following products.
  - a=-128, b=-128 -> product=0x4000.
  - a=-1, b=1 -> product=0xFFFF.
  - a=127, b=-128 -> product=0xC080.
- Backpressure: out_ready=0 for 10 cycles after out_valid rises -> product, out_valid=1 and in_ready=0 are held stable; in_valid pulses in this window are not captured. Release out_ready -> IDLE on the next edge.
- Back-to-back: in_valid held high with operand pairs (3,5), (-7,9) signed and out_ready=1 -> products 15 and 0xFFC1 (-63), each N+2 cycles apart, in order.
- Reset: assert rst_n=0 asynchronously during RUN cycle 2 -> in_ready=1 and out_valid=0 immediately. After release, multiply 6*7 -> 42 with no stale data.
- WIDTH=16, random 2000 signed and unsigned pairs against a reference model -> all products match; latency is 9 cycles.
